// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase sequencer: state codes, lamp encodings,
// default dwell presets and the countdown width.
package traffic_pkg;

  localparam int unsigned TMR_W = 7;

  typedef enum logic [2:0] {
    StAllRed   = 3'd0,
    StNsGreen  = 3'd1,
    StNsYellow = 3'd2,
    StEwGreen  = 3'd3,
    StEwYellow = 3'd4,
    StPedWalk  = 3'd5
  } phase_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [TMR_W-1:0] T_GREEN_DEF  = 7'd30;
  localparam logic [TMR_W-1:0] T_YELLOW_DEF = 7'd4;
  localparam logic [TMR_W-1:0] T_ALLRED_DEF = 7'd1;
  localparam logic [TMR_W-1:0] T_WALK_DEF   = 7'd10;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lamps_t;

  function automatic lamps_t decode_lamps(input phase_e p);
    lamps_t l;
    l = '{ns: LAMP_RED, ew: LAMP_RED, walk: 1'b0};
    unique case (p)
      StNsGreen:  l.ns = LAMP_GRN;
      StNsYellow: l.ns = LAMP_YEL;
      StEwGreen:  l.ew = LAMP_GRN;
      StEwYellow: l.ew = LAMP_YEL;
      StPedWalk:  l.walk = 1'b1;
      default:    l = '{ns: LAMP_RED, ew: LAMP_RED, walk: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ped_req_sync.sv
// Two-flop synchronizer for the raw pedestrian button followed by a rising-edge detector
// that emits a single-cycle pulse.
module ped_req_sync (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic pulse
);

  // [0],[1] are the synchronizer stages, [2] holds the previous synchronized level.
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], req};
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/traffic_phase_fsm.sv
// Phase sequencer: walks the vehicle/pedestrian phases, loads the external countdown on every
// phase entry and advances when the countdown reports expiry.
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter logic [TMR_W-1:0] T_GREEN  = T_GREEN_DEF,
  parameter logic [TMR_W-1:0] T_YELLOW = T_YELLOW_DEF,
  parameter logic [TMR_W-1:0] T_ALLRED = T_ALLRED_DEF,
  parameter logic [TMR_W-1:0] T_WALK   = T_WALK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_req,
  input  logic             tmr_active,
  output logic             tmr_start,
  output logic [TMR_W-1:0] tmr_preset,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic [2:0]       phase
);

  phase_e state_q, state_d;
  logic   next_dir_q, next_dir_d;  // 0 = NS, 1 = EW
  logic   ped_pending_q, ped_pending_d;
  logic   tmr_start_q;
  lamps_t lamps_q, lamps_d;
  logic   expire;
  logic   ped_pulse;
  logic   entering_walk;

  ped_req_sync u_ped_req_sync (
    .clk   (clk),
    .rst   (rst),
    .req   (ped_req),
    .pulse (ped_pulse)
  );

  // The count seen during the load cycle is stale, so expiry is masked while loading.
  assign expire = !tmr_active && !tmr_start_q;

  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    if (expire) begin
      unique case (state_q)
        StNsGreen:  state_d = StNsYellow;
        StNsYellow: begin
          state_d    = StAllRed;
          next_dir_d = 1'b1;
        end
        StEwGreen:  state_d = StEwYellow;
        StEwYellow: begin
          state_d    = StAllRed;
          next_dir_d = 1'b0;
        end
        StAllRed:   state_d = ped_pending_q ? StPedWalk : (next_dir_q ? StEwGreen : StNsGreen);
        StPedWalk:  state_d = next_dir_q ? StEwGreen : StNsGreen;
        default:    state_d = StAllRed;
      endcase
    end
  end

  assign entering_walk = (state_d == StPedWalk) && (state_q != StPedWalk);

  // Clear on walk entry dominates a coincident set; presses during the walk are dropped.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (entering_walk) begin
      ped_pending_d = 1'b0;
    end else if (ped_pulse && (state_q != StPedWalk)) begin
      ped_pending_d = 1'b1;
    end
  end

  always_comb begin
    tmr_preset = T_ALLRED;
    unique case (state_q)
      StNsGreen, StEwGreen:   tmr_preset = T_GREEN;
      StNsYellow, StEwYellow: tmr_preset = T_YELLOW;
      StPedWalk:              tmr_preset = T_WALK;
      default:                tmr_preset = T_ALLRED;
    endcase
  end

  assign lamps_d = decode_lamps(state_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StAllRed;
      next_dir_q    <= 1'b0;
      ped_pending_q <= 1'b0;
      tmr_start_q   <= 1'b1;
      lamps_q       <= '{ns: LAMP_RED, ew: LAMP_RED, walk: 1'b0};
    end else begin
      state_q       <= state_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
      tmr_start_q   <= (state_d != state_q);
      lamps_q       <= lamps_d;
    end
  end

  assign tmr_start = tmr_start_q;
  assign ns_light  = lamps_q.ns;
  assign ew_light  = lamps_q.ew;
  assign walk      = lamps_q.walk;
  assign phase     = state_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Bench for traffic_phase_fsm with a behavioural countdown beside it; phase entries are
// scoreboarded and a second instance covers the zero yellow preset.
module tb_traffic_phase_fsm;
  import traffic_pkg::*;

  localparam logic [6:0] TG = 7'd5;
  localparam logic [6:0] TY = 7'd2;
  localparam logic [6:0] TA = 7'd1;
  localparam logic [6:0] TW = 7'd3;

  localparam logic [2:0] P_AR  = StAllRed;
  localparam logic [2:0] P_NSG = StNsGreen;
  localparam logic [2:0] P_NSY = StNsYellow;
  localparam logic [2:0] P_EWG = StEwGreen;
  localparam logic [2:0] P_EWY = StEwYellow;
  localparam logic [2:0] P_PW  = StPedWalk;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0;
  logic       tmr_active, tmr_start, walk;
  logic [6:0] tmr_preset;
  logic [2:0] ns_light, ew_light, phase;
  logic       tmr_active0, tmr_start0, walk0;
  logic [6:0] tmr_preset0;
  logic [2:0] ns0, ew0, phase0;
  logic [6:0] cnt, cnt0;

  always #5 clk = ~clk;

  traffic_phase_fsm #(.T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW)) dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .tmr_active(tmr_active), .tmr_start(tmr_start),
    .tmr_preset(tmr_preset), .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .phase(phase)
  );

  traffic_phase_fsm #(.T_GREEN(TG), .T_YELLOW(7'd0), .T_ALLRED(TA), .T_WALK(TW)) dut0 (
    .clk(clk), .rst(rst), .ped_req(1'b0), .tmr_active(tmr_active0), .tmr_start(tmr_start0),
    .tmr_preset(tmr_preset0), .ns_light(ns0), .ew_light(ew0), .walk(walk0), .phase(phase0)
  );

  // Behavioural countdown: load on start, then count down to zero; active while non-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      cnt0 <= '0;
    end else begin
      if (tmr_start) cnt <= tmr_preset;
      else if (cnt != 0) cnt <= cnt - 7'd1;
      if (tmr_start0) cnt0 <= tmr_preset0;
      else if (cnt0 != 0) cnt0 <= cnt0 - 7'd1;
    end
  end
  assign tmr_active  = (cnt != 0);
  assign tmr_active0 = (cnt0 != 0);

  typedef struct {
    logic [2:0] ph;
    logic [6:0] preset;
    int         dwell;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] preset_of(input logic [2:0] ph);
    case (ph)
      P_NSG, P_EWG: return TG;
      P_NSY, P_EWY: return TY;
      P_PW:         return TW;
      default:      return TA;
    endcase
  endfunction

  // Expected {ns, ew, walk} for a phase.
  function automatic logic [6:0] lamps_of(input logic [2:0] ph);
    case (ph)
      P_NSG:   return {3'b001, 3'b100, 1'b0};
      P_NSY:   return {3'b010, 3'b100, 1'b0};
      P_EWG:   return {3'b100, 3'b001, 1'b0};
      P_EWY:   return {3'b100, 3'b010, 1'b0};
      P_PW:    return {3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic push(input logic [2:0] ph);
    exp_t e;
    e.ph     = ph;
    e.preset = preset_of(ph);
    e.dwell  = int'(e.preset) + 2;
    sb_q.push_back(e);
  endtask

  task automatic wait_phase(input logic [2:0] ph, input string tag);
    int n = 0;
    while (phase !== ph && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({"reach_", tag}, phase, ph);
  endtask

  // Scoreboard monitor: each tmr_start pops one expected phase entry and closes the previous dwell.
  initial begin
    exp_t       cur;
    bit         have_cur = 1'b0;
    int         in_phase = 0;
    logic [2:0] prev_ph = 3'b111;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_cur = 1'b0;
        in_phase = 0;
        prev_ph  = 3'b111;
      end else begin
        check("start_on_change", tmr_start, phase != prev_ph);
        if (tmr_start) begin
          if (have_cur) check("dwell", in_phase, cur.dwell);
          if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
            have_cur = 1'b0;
          end else begin
            cur      = sb_q.pop_front();
            have_cur = 1'b1;
            check("phase", phase, cur.ph);
            check("preset", tmr_preset, cur.preset);
          end
          in_phase = 1;
        end else begin
          in_phase++;
        end
        check("lamps", {ns_light, ew_light, walk}, lamps_of(phase));
        check("ns_onehot", $onehot(ns_light), 1);
        check("ew_onehot", $onehot(ew_light), 1);
        check("no_dual_green", ns_light[0] & ew_light[0], 0);
        prev_ph = phase;
      end
    end
  end

  // Zero-preset instance: measure the first NS_YELLOW.
  int         y0_len = 0;
  bit         y0_act = 1'b0;
  bit         y0_done = 1'b0;
  logic [2:0] y0_next = 3'b111;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !y0_done) begin
        if (phase0 == P_NSY) begin
          y0_len++;
          if (tmr_active0 !== 1'b0) y0_act = 1'b1;
        end else if (y0_len != 0) begin
          y0_done = 1'b1;
          y0_next = phase0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_phase", phase, P_AR);
    check("rst_start", tmr_start, 1);
    check("rst_preset", tmr_preset, TA);
    check("rst_lamps", {ns_light, ew_light, walk}, {3'b100, 3'b100, 1'b0});
    check("rst_pending", dut.ped_pending_q, 0);

    push(P_AR);  push(P_NSG); push(P_NSY); push(P_AR);  push(P_EWG); push(P_EWY);
    push(P_AR);  push(P_NSG); push(P_NSY); push(P_AR);  push(P_PW);  push(P_EWG);
    push(P_EWY); push(P_AR);  push(P_NSG); push(P_NSY); push(P_AR);  push(P_EWG);
    push(P_EWY);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    wait_phase(P_NSG, "nsg1");
    check("nsg_ns", ns_light, 3'b001);
    check("nsg_ew", ew_light, 3'b100);

    // Single-cycle press in the middle of the second NS green.
    wait_phase(P_EWG, "ewg1");
    wait_phase(P_NSG, "nsg2");
    repeat (2) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_phase(P_NSY, "nsy2");
    check("pending_latched", dut.ped_pending_q, 1);

    // Hold the button across the whole walk; it must not earn a second walk.
    wait_phase(P_PW, "walk");
    check("walk_pending_clr", dut.ped_pending_q, 0);
    check("walk_lamp", walk, 1);
    check("walk_ns", ns_light, 3'b100);
    check("walk_ew", ew_light, 3'b100);
    ped_req = 1'b1;
    wait_phase(P_EWG, "ewg_after_walk");
    ped_req = 1'b0;
    check("press_in_walk_ignored", dut.ped_pending_q, 0);
    wait_phase(P_AR, "ar_after_walk");
    wait_phase(P_NSG, "nsg_no_walk");

    // Mid-phase reset during EW yellow.
    wait_phase(P_EWY, "ewy");
    repeat (2) @(negedge clk);
    check("sb_drained_pre_rst", sb_q.size(), 0);
    rst = 1'b1;
    #1;
    check("mrst_phase", phase, P_AR);
    check("mrst_start", tmr_start, 1);
    check("mrst_preset", tmr_preset, TA);
    check("mrst_lamps", {ns_light, ew_light, walk}, {3'b100, 3'b100, 1'b0});
    check("mrst_pending", dut.ped_pending_q, 0);
    repeat (2) @(negedge clk);
    push(P_AR); push(P_NSG); push(P_NSY);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    wait_phase(P_NSG, "nsg_after_rst");
    wait_phase(P_NSY, "nsy_after_rst");
    @(negedge clk);
    check("sb_drained_end", sb_q.size(), 0);

    check("zero_yellow_seen", y0_done, 1);
    check("zero_yellow_len", y0_len, 2);
    check("zero_yellow_active", y0_act, 0);
    check("zero_yellow_next", y0_next, P_AR);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_phase_fsm.md
# traffic_phase_fsm

Phase sequencer for the traffic controller. It sits directly upstream of the `countdown` timer: it issues the load pulse and preset duration for each phase and advances when the timer reports expiry. It drives the north-south and east-west lamp outputs and the pedestrian walk lamp, and latches pedestrian requests so they are served between vehicle phases.

## Interface
- `T_GREEN`, default 30: green dwell preset, in timer ticks; range 0..127.
- `T_YELLOW`, default 4: yellow dwell preset.
- `T_ALLRED`, default 1: all-red clearance preset.
- `T_WALK`, default 10: pedestrian walk preset.
- `clk`  in  1  single clock, rising edge; also the timer clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `ped_req`  in  1  raw pedestrian button (level, asynchronous).
- `tmr_active`  in  1  countdown `active`; high while the count is non-zero.
- `tmr_start`  out  1  one-cycle load pulse to countdown `start`.
- `tmr_preset`  out  7  countdown `preset_value`; valid whenever `tmr_start` is high.
- `ns_light`  out  3  {red, yellow, green}, one-hot.
- `ew_light`  out  3  {red, yellow, green}, one-hot.
- `walk`  out  1  pedestrian walk lamp.
- `phase`  out  3  current state code (debug).

## Operation
- The design has one clock and one reset. Reset is asynchronous and active-high.
- States: `ALL_RED`, `NS_GREEN`, `NS_YELLOW`, `EW_GREEN`, `EW_YELLOW`, `PED_WALK`.
- Internal register `next_dir` (0 = NS, 1 = EW) and flag `ped_pending`.
- Expiry condition: `expire = !tmr_active && !tmr_start`. Qualifying with `!tmr_start` masks the stale zero count present in the load cycle.
- Transitions, taken only on `expire`:
  - `NS_GREEN` → `NS_YELLOW`; `NS_YELLOW` → `ALL_RED`, setting `next_dir` = EW.
  - `EW_GREEN` → `EW_YELLOW`; `EW_YELLOW` → `ALL_RED`, setting `next_dir` = NS.
  - `ALL_RED` → `PED_WALK` if `ped_pending`, otherwise to the green of `next_dir`.
  - `PED_WALK` → the green of `next_dir`. No extra all-red is inserted, because all vehicle lamps were already red.
- Every state change asserts `tmr_start` for exactly the first cycle in the new state. In that same cycle `tmr_preset` carries the new state's `T_*` value.
- Lamps decode from the state, registered:
  - Red on both directions in `ALL_RED` and `PED_WALK`.
  - The opposing direction shows red during any green or yellow.
  - `walk` = 1 only in `PED_WALK`.
- Pedestrian request handling:
  - `ped_req` passes through a 2-flop synchronizer, then a rising-edge detect sets `ped_pending`.
  - Entering `PED_WALK` clears `ped_pending`. If a set and a clear occur in the same cycle, the clear wins.
  - Presses while in `PED_WALK` are ignored.
  - Presses in any other state are held until the next `ALL_RED` exit.
- A preset of 0 is legal: the timer never goes active, and the phase still lasts 2 cycles.

## Timing
- Reset values:
  - `phase` = `ALL_RED`, `next_dir` = NS, `ped_pending` = 0, synchronizer = 0.
  - `tmr_start` = 1 and `tmr_preset` = `T_ALLRED`, so the timer loads on the first edge after reset release.
  - `ns_light` = `ew_light` = 3'b100, `walk` = 0.
- Dwell per phase = preset + 2 cycles:
  - 1 cycle for the load, preset cycles with `tmr_active` high, then 1 expiry cycle.
  - The transition occurs on the edge that ends the expiry cycle.
- `ped_req` to `ped_pending` latency: 3 edges (2 synchronizer stages plus the set).
- If `rst` is asserted mid-phase, all registers return to their reset values immediately. The countdown is reloaded by the `tmr_start` = 1 reset value.
- `tmr_active` is trusted only when `tmr_start` = 0.

## Structure
- Shared package `traffic_pkg` holds:
  - the state enum and its 3-bit encodings;
  - lamp constants `LAMP_RED` = 3'b100, `LAMP_YEL` = 3'b010, `LAMP_GRN` = 3'b001;
  - the default `T_*` localparams;
  - the timer width constant `TMR_W` = 7.
- One sub-module, `ped_req_sync`, performs the 2-flop synchronization and rising-edge detection and outputs a 1-cycle pulse.
- The countdown is instantiated beside this block at the top level, not inside it.

## Test plan
All scenarios use the real countdown with T_GREEN=5, T_YELLOW=2, T_ALLRED=1, T_WALK=3.

- **Reset release, no requests:** `phase` follows ALL_RED (3 cycles) → NS_GREEN (7) → NS_YELLOW (4) → ALL_RED (3) → EW_GREEN (7). `tmr_start` pulses exactly once per entry, with presets 1, 5, 2, 1, 5.
- **Lamp check:** throughout the sequence, `ns_light` and `ew_light` are always one-hot, and green never appears on both directions at once. During NS_GREEN, `ns_light` = 001 and `ew_light` = 100.
- **Pedestrian request:**
  - Pulse `ped_req` for 1 cycle mid NS_GREEN.
  - Required: after NS_YELLOW and ALL_RED comes PED_WALK (5 cycles, `walk` = 1, both lamps 100), then EW_GREEN.
  - `ped_pending` is 0 after PED_WALK entry.
- **Press during walk:** hold `ped_req` high throughout PED_WALK → no second PED_WALK at the following ALL_RED.
- **Zero preset:** T_YELLOW=0 → NS_YELLOW lasts exactly 2 cycles, and `tmr_active` never rises in it.
- **Mid-phase reset:** assert `rst` during EW_YELLOW → outputs immediately take reset values; after release, the sequence restarts ALL_RED → NS_GREEN.
